// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default widths, register-zero address and word/address types.
package cpu_pkg;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_NUM_REGS = 32;
  localparam int DEF_AW       = $clog2(DEF_NUM_REGS);

  typedef logic [DEF_AW-1:0]     reg_addr_t;
  typedef logic [DEF_DATA_W-1:0] word_t;

  localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/cpu_regfile_rdport.sv
// One read port: forward / constant / write-through / array priority mux feeding the p3 register.
module cpu_regfile_rdport
  import cpu_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int NUM_FWD = 2,
  parameter int AW      = DEF_AW
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      stall,
  input  logic [AW-1:0]             rd_addr,
  input  logic [NUM_FWD-1:0]        fwd_sel,
  input  logic [NUM_FWD*DATA_W-1:0] fwd_data,
  input  logic                      const_sel,
  input  logic [DATA_W-1:0]         const_val,
  input  logic                      wr_fire,
  input  logic [AW-1:0]             wr_addr,
  input  logic [DATA_W-1:0]         wr_data,
  input  logic [DATA_W-1:0]         arr_data,
  output logic [DATA_W-1:0]         p3_data
);

  logic [DATA_W-1:0] p3_data_d, p3_data_q;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_val;

  // Scan from the oldest source down so the youngest selected source wins.
  always_comb begin
    fwd_hit = 1'b0;
    fwd_val = '0;
    for (int j = NUM_FWD - 1; j >= 0; j--) begin
      if (fwd_sel[j]) begin
        fwd_hit = 1'b1;
        fwd_val = fwd_data[j*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    p3_data_d = p3_data_q;
    if (!stall) begin
      if (fwd_hit)
        p3_data_d = fwd_val;
      else if (const_sel)
        p3_data_d = const_val;
      else if (wr_fire && (wr_addr == rd_addr))
        p3_data_d = wr_data;
      else if (rd_addr == REG_ZERO)
        p3_data_d = '0;
      else
        p3_data_d = arr_data;
    end
  end

  // p2 -> p3 boundary
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) p3_data_q <= '0;
    else          p3_data_q <= p3_data_d;
  end

  assign p3_data = p3_data_q;

endmodule

// File: rtl/cpu_regfile_fwd.sv
// Register file with forwarding, constant substitution and write-through between decode and execute.
// REGFILE_SCOREBOARD_EN adds the pending-load busy bits and the p2_hazard flag.
module cpu_regfile_fwd
  import cpu_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int NUM_READ = 3,
  parameter int NUM_FWD  = 2
) (
  input  logic                                        clock,
  input  logic                                        reset_n,
  input  logic                                        stall,
  input  logic [NUM_READ*$clog2(NUM_REGS)-1:0]        p2_rd_addr,
  input  logic [NUM_READ-1:0]                         p2_rd_valid,
  input  logic [NUM_READ*NUM_FWD-1:0]                 p2_fwd_sel,
  input  logic [DATA_W-1:0]                           p2_const,
  input  logic [NUM_READ-1:0]                         p2_const_sel,
  input  logic [NUM_FWD*DATA_W-1:0]                   fwd_data,
  output logic [NUM_READ*DATA_W-1:0]                  p3_data,
  output logic [DATA_W-1:0]                           p3_const,
  input  logic [$clog2(NUM_REGS)-1:0]                 p4_wr_addr,
  input  logic [DATA_W-1:0]                           p4_wr_data,
  input  logic                                        p4_wr_en,
  input  logic                                        p2_load_issue,
  input  logic [$clog2(NUM_REGS)-1:0]                 p2_load_reg,
  output logic                                        p2_hazard
);

  localparam int AW = $clog2(NUM_REGS);

  logic              wr_fire;
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] p3_const_d, p3_const_q;

  assign wr_fire = p4_wr_en && !stall && (p4_wr_addr != AW'(REG_ZERO));

  always_comb begin
    regs_d = regs_q;
    if (wr_fire) regs_d[p4_wr_addr] = p4_wr_data;
  end

  always_comb begin
    p3_const_d = stall ? p3_const_q : p2_const;
  end

  // p4 write-back into the array; p2 -> p3 boundary for the constant
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
      p3_const_q <= '0;
    end else begin
      regs_q     <= regs_d;
      p3_const_q <= p3_const_d;
    end
  end

  assign p3_const = p3_const_q;

  for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
    cpu_regfile_rdport #(
      .DATA_W  (DATA_W),
      .NUM_FWD (NUM_FWD),
      .AW      (AW)
    ) u_rdport (
      .clock     (clock),
      .reset_n   (reset_n),
      .stall     (stall),
      .rd_addr   (p2_rd_addr[i*AW +: AW]),
      .fwd_sel   (p2_fwd_sel[i*NUM_FWD +: NUM_FWD]),
      .fwd_data  (fwd_data),
      .const_sel (p2_const_sel[i]),
      .const_val (p2_const),
      .wr_fire   (wr_fire),
      .wr_addr   (p4_wr_addr),
      .wr_data   (p4_wr_data),
      .arr_data  (regs_q[p2_rd_addr[i*AW +: AW]]),
      .p3_data   (p3_data[i*DATA_W +: DATA_W])
    );
  end

`ifdef REGFILE_SCOREBOARD_EN
  logic [NUM_REGS-1:0] busy_d, busy_q;
  logic                ld_fire;
  logic [AW-1:0]       hz_addr;

  assign ld_fire = p2_load_issue && !stall && (p2_load_reg != AW'(REG_ZERO));

  // The set is applied after the clear so a newer load stays outstanding.
  always_comb begin
    busy_d = busy_q;
    if (wr_fire) busy_d[p4_wr_addr]  = 1'b0;
    if (ld_fire) busy_d[p2_load_reg] = 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) busy_q <= '0;
    else          busy_q <= busy_d;
  end

  // A write-back landing this cycle is covered by write-through, so it masks the hazard.
  always_comb begin
    p2_hazard = 1'b0;
    hz_addr   = '0;
    for (int i = 0; i < NUM_READ; i++) begin
      hz_addr = p2_rd_addr[i*AW +: AW];
      if (p2_rd_valid[i] && !p2_const_sel[i] &&
          (p2_fwd_sel[i*NUM_FWD +: NUM_FWD] == '0) &&
          (hz_addr != AW'(REG_ZERO)) && busy_q[hz_addr] &&
          !(wr_fire && (p4_wr_addr == hz_addr)))
        p2_hazard = 1'b1;
    end
  end
`else
  logic unused_sb;
  assign unused_sb = ^{p2_load_issue, p2_load_reg, p2_rd_valid};
  assign p2_hazard = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_regfile_fwd.sv
// Self-checking bench for cpu_regfile_fwd: directed vector table, scoreboard/stall/reset sequences, random run vs model.
module tb_cpu_regfile_fwd;
  import cpu_pkg::*;

  localparam int DW  = 32;
  localparam int NR  = 32;
  localparam int NRD = 3;
  localparam int NF  = 2;
  localparam int AWL = 5;
`ifdef REGFILE_SCOREBOARD_EN
  localparam bit SB_EN = 1'b1;
`else
  localparam bit SB_EN = 1'b0;
`endif

  logic               clock, reset_n, stall;
  logic [NRD*AWL-1:0] p2_rd_addr;
  logic [NRD-1:0]     p2_rd_valid;
  logic [NRD*NF-1:0]  p2_fwd_sel;
  logic [DW-1:0]      p2_const;
  logic [NRD-1:0]     p2_const_sel;
  logic [NF*DW-1:0]   fwd_data;
  logic [NRD*DW-1:0]  p3_data;
  logic [DW-1:0]      p3_const;
  logic [AWL-1:0]     p4_wr_addr;
  logic [DW-1:0]      p4_wr_data;
  logic               p4_wr_en;
  logic               p2_load_issue;
  logic [AWL-1:0]     p2_load_reg;
  logic               p2_hazard;

  cpu_regfile_fwd #(.DATA_W(DW), .NUM_REGS(NR), .NUM_READ(NRD), .NUM_FWD(NF)) dut (
    .clock(clock), .reset_n(reset_n), .stall(stall),
    .p2_rd_addr(p2_rd_addr), .p2_rd_valid(p2_rd_valid), .p2_fwd_sel(p2_fwd_sel),
    .p2_const(p2_const), .p2_const_sel(p2_const_sel), .fwd_data(fwd_data),
    .p3_data(p3_data), .p3_const(p3_const),
    .p4_wr_addr(p4_wr_addr), .p4_wr_data(p4_wr_data), .p4_wr_en(p4_wr_en),
    .p2_load_issue(p2_load_issue), .p2_load_reg(p2_load_reg), .p2_hazard(p2_hazard)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  word_t mregs [NR];
  bit    mbusy [NR];
  word_t mp3   [NRD];
  word_t mconst;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < NR; r++) begin mregs[r] = '0; mbusy[r] = 1'b0; end
    for (int i = 0; i < NRD; i++) mp3[i] = '0;
    mconst = '0;
  endtask

  function automatic word_t port_pred(int i);
    logic [AWL-1:0] a;
    a = p2_rd_addr[i*AWL +: AWL];
    for (int j = 0; j < NF; j++)
      if (p2_fwd_sel[i*NF + j]) return fwd_data[j*DW +: DW];
    if (p2_const_sel[i]) return p2_const;
    if (p4_wr_en && !stall && p4_wr_addr == a && a != 0) return p4_wr_data;
    return (a == 0) ? '0 : mregs[a];
  endfunction

  function automatic bit haz_pred();
    logic [AWL-1:0] a;
    for (int i = 0; i < NRD; i++) begin
      a = p2_rd_addr[i*AWL +: AWL];
      if (SB_EN && p2_rd_valid[i] && !p2_const_sel[i] && p2_fwd_sel[i*NF +: NF] == 0 &&
          a != 0 && mbusy[a] && !(p4_wr_en && !stall && p4_wr_addr == a))
        return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic idle();
    stall = 0; p2_rd_addr = '0; p2_rd_valid = '0; p2_fwd_sel = '0; p2_const = '0;
    p2_const_sel = '0; fwd_data = '0; p4_wr_addr = '0; p4_wr_data = '0; p4_wr_en = 0;
    p2_load_issue = 0; p2_load_reg = '0;
  endtask

  // One clock: check the hazard before the edge, predict p3/state, check p3 after it.
  task automatic cycle();
    word_t nxt [NRD];
    word_t nc;
    #1;
    chk("hazard", 32'(p2_hazard), 32'(haz_pred()));
    for (int i = 0; i < NRD; i++) nxt[i] = stall ? mp3[i] : port_pred(i);
    nc = stall ? mconst : p2_const;
    @(posedge clock);
    #1;
    if (!stall) begin
      if (p4_wr_en && p4_wr_addr != 0) begin
        mregs[p4_wr_addr] = p4_wr_data;
        mbusy[p4_wr_addr] = 1'b0;
      end
      if (SB_EN && p2_load_issue && p2_load_reg != 0) mbusy[p2_load_reg] = 1'b1;
    end
    mp3 = nxt;
    mconst = nc;
    for (int i = 0; i < NRD; i++)
      chk($sformatf("p3_data[%0d]", i), p3_data[i*DW +: DW], mp3[i]);
    chk("p3_const", p3_const, mconst);
  endtask

  typedef struct {
    bit             we;
    logic [AWL-1:0] wa;
    word_t          wd;
    logic [AWL-1:0] a0, a1, a2;
    logic [5:0]     fsel;
    logic [2:0]     csel;
    word_t          k, f0, f1;
    word_t          e0, e1, e2;
  } vec_t;

  vec_t vt [8];

  initial begin
    vt[0] = '{0, 5'd0, 32'h0,        5'd5, 5'd5, 5'd5, 6'b000000, 3'b000, 32'h0,    32'h0,  32'h0,  32'h0,        32'h0,        32'h0};
    vt[1] = '{1, 5'd3, 32'h12345678, 5'd3, 5'd5, 5'd0, 6'b000000, 3'b000, 32'h0,    32'h0,  32'h0,  32'h12345678, 32'h0,        32'h0};
    vt[2] = '{0, 5'd0, 32'h0,        5'd3, 5'd7, 5'd3, 6'b000000, 3'b000, 32'h0,    32'h0,  32'h0,  32'h12345678, 32'h0,        32'h12345678};
    vt[3] = '{1, 5'd7, 32'h11,       5'd7, 5'd3, 5'd0, 6'b000000, 3'b000, 32'h0,    32'h0,  32'h0,  32'h11,       32'h12345678, 32'h0};
    vt[4] = '{0, 5'd0, 32'h0,        5'd7, 5'd7, 5'd7, 6'b001100, 3'b100, 32'hC0DE, 32'hAA, 32'hBB, 32'h11,       32'hAA,       32'hC0DE};
    vt[5] = '{0, 5'd0, 32'h0,        5'd7, 5'd7, 5'd3, 6'b000010, 3'b010, 32'h5555, 32'hAA, 32'hBB, 32'hBB,       32'h5555,     32'h12345678};
    vt[6] = '{1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd0, 6'b000000, 3'b000, 32'h0,    32'h0,  32'h0,  32'h0,        32'h0,        32'h0};
    vt[7] = '{0, 5'd0, 32'h0,        5'd0, 5'd0, 5'd0, 6'b010000, 3'b000, 32'h0,    32'hAA, 32'hBB, 32'h0,        32'h0,        32'hAA};

    idle();
    reset_n = 1'b0;
    model_reset();
    #12;
    for (int i = 0; i < NRD; i++) chk("reset_p3", p3_data[i*DW +: DW], 32'h0);
    chk("reset_const", p3_const, 32'h0);
    chk("reset_hazard", 32'(p2_hazard), 32'h0);
    reset_n = 1'b1;
    @(posedge clock); #1;

    // Directed table
    for (int v = 0; v < 8; v++) begin
      idle();
      p4_wr_en = vt[v].we; p4_wr_addr = vt[v].wa; p4_wr_data = vt[v].wd;
      p2_rd_addr = {vt[v].a2, vt[v].a1, vt[v].a0};
      p2_fwd_sel = vt[v].fsel; p2_const_sel = vt[v].csel; p2_const = vt[v].k;
      fwd_data = {vt[v].f1, vt[v].f0};
      cycle();
      chk($sformatf("vec%0d_p0", v), p3_data[31:0],  vt[v].e0);
      chk($sformatf("vec%0d_p1", v), p3_data[63:32], vt[v].e1);
      chk($sformatf("vec%0d_p2", v), p3_data[95:64], vt[v].e2);
    end

    // Scoreboard sequences
    idle(); p2_load_issue = 1; p2_load_reg = 5'd0; cycle();
    idle(); p2_rd_valid = 3'b001; #1 chk("haz_r0", 32'(p2_hazard), 32'h0); cycle();
    idle(); p2_load_issue = 1; p2_load_reg = 5'd9; cycle();
    idle(); p2_rd_addr[14:10] = 5'd9; p2_rd_valid = 3'b100;
    #1 chk("haz_r9", 32'(p2_hazard), 32'(SB_EN)); cycle();
    p4_wr_en = 1; p4_wr_addr = 5'd9; p4_wr_data = 32'hCAFE0009;
    #1 chk("haz_r9_wb", 32'(p2_hazard), 32'h0); cycle();
    chk("wt_r9", p3_data[95:64], 32'hCAFE0009);
    idle(); p2_rd_addr[14:10] = 5'd9; p2_rd_valid = 3'b100;
    #1 chk("haz_r9_clr", 32'(p2_hazard), 32'h0); cycle();
    idle(); p2_load_issue = 1; p2_load_reg = 5'd9; p4_wr_en = 1; p4_wr_addr = 5'd9; p4_wr_data = 32'h99;
    cycle();
    idle(); p2_rd_addr[14:10] = 5'd9; p2_rd_valid = 3'b100;
    #1 chk("haz_set_wins", 32'(p2_hazard), 32'(SB_EN)); cycle();

    // Stall: everything holds, hazard still reported
    stall = 1; p4_wr_en = 1; p4_wr_addr = 5'd3; p4_wr_data = 32'hDEADBEEF;
    p2_load_issue = 1; p2_load_reg = 5'd12; p2_const = 32'h77; fwd_data = {32'h1, 32'h2};
    p2_rd_addr[4:0] = 5'd3;
    #1 chk("haz_stall", 32'(p2_hazard), 32'(SB_EN)); cycle();
    chk("stall_hold_p2", p3_data[95:64], 32'h99);
    chk("stall_hold_const", p3_const, 32'h0);
    idle(); p2_rd_addr[4:0] = 5'd3; p2_rd_addr[9:5] = 5'd12; p2_rd_valid = 3'b010;
    #1 chk("haz_r12", 32'(p2_hazard), 32'h0); cycle();
    chk("r3_after_stall", p3_data[31:0], 32'h12345678);

    // Random run against the model
    for (int n = 0; n < 400; n++) begin
      stall = ($urandom_range(0, 7) == 0);
      for (int i = 0; i < NRD; i++) p2_rd_addr[i*AWL +: AWL] = AWL'($urandom_range(0, 7));
      p2_rd_valid = NRD'($urandom);
      p2_fwd_sel = ($urandom_range(0, 3) == 0) ? (NRD*NF)'($urandom) : '0;
      p2_const_sel = ($urandom_range(0, 3) == 0) ? NRD'($urandom) : '0;
      p2_const = $urandom;
      fwd_data = {$urandom, $urandom};
      p4_wr_en = $urandom_range(0, 1);
      p4_wr_addr = AWL'($urandom_range(0, 7));
      p4_wr_data = $urandom;
      p2_load_issue = ($urandom_range(0, 2) == 0);
      p2_load_reg = AWL'($urandom_range(0, 7));
      cycle();
    end

    // Asynchronous reset in the middle of a stall
    idle(); stall = 1; p4_wr_en = 1; p4_wr_addr = 5'd4; p4_wr_data = 32'h5A5A;
    p2_rd_addr[14:10] = 5'd9; p2_rd_valid = 3'b100;
    #2 reset_n = 1'b0;
    #1;
    for (int i = 0; i < NRD; i++) chk("async_reset_p3", p3_data[i*DW +: DW], 32'h0);
    chk("async_reset_const", p3_const, 32'h0);
    chk("async_reset_hazard", 32'(p2_hazard), 32'h0);
    model_reset();
    idle();
    @(negedge clock);
    reset_n = 1'b1;
    p2_rd_addr[4:0] = 5'd3; p2_rd_addr[9:5] = 5'd7;
    cycle();
    chk("r3_after_reset", p3_data[31:0], 32'h0);
    chk("r7_after_reset", p3_data[63:32], 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
